wb_burst_master: RTL and testbench

Synthesizable Wishbone B3 master sitting directly upstream of the SDRAM controller's Wishbone slave port (wb_stb_i/wb_cyc_i/wb_cti_i/wb_ack_o).
Converts a command request (address, length, direction) plus a streamed write-data channel into incrementing Wishbone bursts, and returns read data as a valid-qualified stream.
Includes an ack-timeout watchdog so a hung slave cannot lock the requester.

---
 rtl/wb_master_pkg.sv | 18 +
 rtl/wb_master_timeout.sv | 46 ++++
 rtl/wb_burst_master.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared types and constants for the Wishbone burst master
//
// Purpose : FSM state encoding and Wishbone cycle-type identifier codes.
// Ports   : none (package).
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_WR      = 2'd2,
        ST_RD      = 2'd3
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_master_timeout.sv
// rtl/wb_master_timeout.sv - ack-timeout watchdog counter
//
// Purpose : counts cycles spent with strobe high and no acknowledge; flags
//           expiry once the count reaches TIMEOUT.
// Ports   : sys_clk, RESETN - clock, asynchronous active-low reset
//           clr             - force count to zero (has priority over en)
//           en              - advance count by one
//           expire          - count has reached TIMEOUT
module wb_master_timeout
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic RESETN,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            // Saturate rather than wrap so expiry cannot be missed.
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q >= LIMIT);

endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - Wishbone B3 incrementing-burst master with timeout
//
// Purpose : accepts a command (address, length, direction), runs it as an
//           incrementing Wishbone burst, streams write data in and read data
//           out, and aborts if the slave stops acknowledging.
// Ports   : sys_clk, RESETN                 - clock, async active-low reset
//           req_valid/req_ready/req_we/
//           req_addr/req_len                - command channel
//           wr_data/wr_valid/wr_ready       - write-data stream
//           rd_data/rd_valid/rd_last        - read-data stream
//           done/err                        - completion / abort pulses
//           wb_*                            - Wishbone master interface
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int BL      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [BL-1:0]     req_len,
    input  logic [DW-1:0]     wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam int            BW         = BL + 1;
    localparam logic [AW-1:0] ADDR_STEP  = AW'(DW / 8);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(DW / 8 - 1);
    localparam logic [BW-1:0] ONE_BEAT   = BW'(1);

    state_e          state_q,    state_d;
    logic [AW-1:0]   addr_q,     addr_d;
    logic [BW-1:0]   beats_q,    beats_d;
    logic            we_q,       we_d;
    logic            cyc_q,      cyc_d;
    logic            stb_q,      stb_d;
    logic [DW-1:0]   dat_q,      dat_d;
    logic [DW-1:0]   rd_data_q,  rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q,  rd_last_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;

    logic ack_eff;
    logic last_beat;
    logic expire;

    // An acknowledge only counts while the strobe is actually asserted.
    assign ack_eff   = wb_ack_i & stb_q;
    assign last_beat = (beats_q == ONE_BEAT);

    wb_master_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .sys_clk (sys_clk),
        .RESETN  (RESETN),
        .clr     (~stb_q | ack_eff),
        .en      (stb_q & ~wb_ack_i),
        .expire  (expire)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        dat_d      = dat_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr & ALIGN_MASK;
                    // Zero length encodes the full 2^BL beats.
                    beats_d = {(req_len == '0), req_len};
                    we_d    = req_we;
                    cyc_d   = 1'b1;
                    if (req_we) begin
                        stb_d   = 1'b0;
                        state_d = ST_WR_WAIT;
                    end else begin
                        stb_d   = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end

            ST_WR_WAIT: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    dat_d   = wr_data;
                    stb_d   = 1'b1;
                    state_d = ST_WR;
                end
            end

            ST_WR: begin
                if (ack_eff) begin
                    addr_d  = addr_q + ADDR_STEP;
                    beats_d = beats_q - ONE_BEAT;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Pull the next beat in the ack cycle so the burst
                        // stays back-to-back when data is ready.
                        wr_ready = 1'b1;
                        if (wr_valid) begin
                            dat_d = wr_data;
                        end else begin
                            stb_d   = 1'b0;
                            state_d = ST_WR_WAIT;
                        end
                    end
                end else if (expire) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end

            ST_RD: begin
                if (ack_eff) begin
                    rd_data_d  = wb_dat_i;
                    rd_valid_d = 1'b1;
                    rd_last_d  = last_beat;
                    addr_d     = addr_q + ADDR_STEP;
                    beats_d    = beats_q - ONE_BEAT;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (expire) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            dat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            dat_q      <= dat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = {(DW / 8){cyc_q}};
    assign wb_cti_o  = !cyc_q    ? CTI_CLASSIC :
                       last_beat ? CTI_EOB     : CTI_INCR;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - directed self-checking bench for wb_burst_master
module tb_wb_burst_master;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BL = 5;
    localparam int TO = 16;

    logic           sys_clk = 1'b0;
    logic           RESETN  = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [BL-1:0]  req_len = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [DW-1:0]  rd_data;
    logic           rd_valid;
    logic           rd_last;
    logic           done;
    logic           err;
    logic           wb_cyc_o;
    logic           wb_stb_o;
    logic           wb_we_o;
    logic [AW-1:0]  wb_addr_o;
    logic [DW-1:0]  wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]     wb_cti_o;
    logic           wb_ack_i;
    logic [DW-1:0]  wb_dat_i;

    logic ack_en     = 1'b0;
    logic ack_always = 1'b0;

    always #5 sys_clk = ~sys_clk;

    // Slave model: acks while strobed (or unconditionally when ack_always),
    // returns data derived from the address.
    assign wb_ack_i = ack_en & (wb_stb_o | ack_always);
    assign wb_dat_i = {6'd0, wb_addr_o} ^ 32'hC0DE_0000;

    wb_burst_master #(.AW(AW), .DW(DW), .BL(BL), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    int checks = 0;
    int passes = 0;

    // Observations gathered by run_burst
    logic [AW-1:0] obs_addr [64];
    logic [2:0]    obs_cti  [64];
    logic [DW-1:0] obs_dat  [64];
    logic [DW-1:0] obs_rd   [64];
    int n_ack, n_rd, n_last, last_idx, first_stb, last_ack_cyc, done_cyc;
    logic err_seen, stb_drop;

    function automatic logic [DW-1:0] wdata(int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic logic [DW-1:0] rexp(logic [AW-1:0] a);
        return {6'd0, a} ^ 32'hC0DE_0000;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_burst(input logic we, input logic [AW-1:0] addr,
                             input logic [BL-1:0] len, input int gap_beat,
                             input int gap_cyc);
        int wi;
        int gl;
        logic fire;
        logic stb_seen;
        wi = 0; gl = gap_cyc; stb_seen = 1'b0;
        n_ack = 0; n_rd = 0; n_last = 0; last_idx = -1; first_stb = -1;
        last_ack_cyc = -1; done_cyc = -1; err_seen = 1'b0; stb_drop = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len;
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rd_valid) begin
                obs_rd[n_rd] = rd_data;
                if (rd_last) begin last_idx = n_rd; n_last++; end
                n_rd++;
            end
            if (done) begin done_cyc = c; break; end
            if (err)  begin err_seen = 1'b1; break; end
            if (wb_stb_o) begin
                if (first_stb < 0) first_stb = c;
                stb_seen = 1'b1;
            end
            if (wb_cyc_o && !wb_stb_o && stb_seen) stb_drop = 1'b1;
            if (wb_stb_o && wb_ack_i) begin
                obs_addr[n_ack] = wb_addr_o;
                obs_cti[n_ack]  = wb_cti_o;
                obs_dat[n_ack]  = we ? wb_dat_o : wb_dat_i;
                last_ack_cyc = c;
                n_ack++;
            end
            wr_valid = we && !(wi == gap_beat && gl > 0);
            wr_data  = wdata(wi);
            fire = wr_valid & wr_ready;
            if (!wr_valid && we && wi == gap_beat && gl > 0) gl--;
            step();
            if (fire) wi++;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b exp 1", req_ready); else passes++;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL reset_cyc_stb_we got %b exp 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else passes++;
        checks++; if ({done, err, rd_valid, rd_last, wr_ready} !== 5'b0) $display("FAIL reset_pulses got %b exp 00000", {done, err, rd_valid, rd_last, wr_ready}); else passes++;
        checks++; if (wb_sel_o !== 4'h0 || wb_cti_o !== 3'b000) $display("FAIL reset_sel_cti got %h/%b exp 0/000", wb_sel_o, wb_cti_o); else passes++;
        checks++; if (wb_addr_o !== '0 || wb_dat_o !== '0 || rd_data !== '0) $display("FAIL reset_data got %h/%h/%h exp 0", wb_addr_o, wb_dat_o, rd_data); else passes++;
    endtask

    task automatic test_read4();
        ack_en = 1'b1;
        run_burst(1'b0, 26'h40, 5'd4, -1, 0);
        checks++; if (n_ack !== 4) $display("FAIL rd4_beats got %0d exp 4", n_ack); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_addr[i] !== 26'(32'h40 + 4 * i)) $display("FAIL rd4_addr%0d got %h exp %h", i, obs_addr[i], 32'h40 + 4 * i); else passes++;
            checks++; if (obs_cti[i] !== ((i == 3) ? 3'b111 : 3'b010)) $display("FAIL rd4_cti%0d got %b", i, obs_cti[i]); else passes++;
            checks++; if (obs_rd[i] !== rexp(26'(32'h40 + 4 * i))) $display("FAIL rd4_data%0d got %h exp %h", i, obs_rd[i], rexp(26'(32'h40 + 4 * i))); else passes++;
        end
        checks++; if (n_rd !== 4 || n_last !== 1 || last_idx !== 3) $display("FAIL rd4_stream got n=%0d last=%0d idx=%0d exp 4/1/3", n_rd, n_last, last_idx); else passes++;
        checks++; if (first_stb !== 0) $display("FAIL rd4_stb_latency got %0d exp 0", first_stb); else passes++;
        checks++; if (done_cyc - last_ack_cyc !== 1) $display("FAIL rd4_done_latency got %0d exp 1", done_cyc - last_ack_cyc); else passes++;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, req_ready} !== 4'b0001 || wb_cti_o !== 3'b000) $display("FAIL rd4_end_bus got %b cti %b exp 0001 cti 000", {wb_cyc_o, wb_stb_o, wb_we_o, req_ready}, wb_cti_o); else passes++;
        step();
        checks++; if (done !== 1'b0) $display("FAIL rd4_done_pulse got %0b exp 0", done); else passes++;
    endtask

    task automatic test_write8();
        int bad;
        ack_en = 1'b1;
        run_burst(1'b1, 26'h100, 5'd8, -1, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) if (obs_dat[i] !== wdata(i) || obs_addr[i] !== 26'(32'h100 + 4 * i)) bad++;
        checks++; if (n_ack !== 8) $display("FAIL wr8_beats got %0d exp 8", n_ack); else passes++;
        checks++; if (bad !== 0) $display("FAIL wr8_data_order got %0d bad beats exp 0", bad); else passes++;
        checks++; if (stb_drop !== 1'b0) $display("FAIL wr8_stb_drop got %0b exp 0", stb_drop); else passes++;
        checks++; if (first_stb !== 1) $display("FAIL wr8_stb_latency got %0d exp 1", first_stb); else passes++;
        checks++; if (obs_cti[6] !== 3'b010 || obs_cti[7] !== 3'b111) $display("FAIL wr8_cti got %b,%b exp 010,111", obs_cti[6], obs_cti[7]); else passes++;
        checks++; if (done_cyc !== 9 || err_seen !== 1'b0) $display("FAIL wr8_done got cyc %0d err %0b exp 9/0", done_cyc, err_seen); else passes++;
        step();
        step();
        checks++; if (done !== 1'b0 || wb_we_o !== 1'b0) $display("FAIL wr8_done_once got done %0b we %0b exp 0/0", done, wb_we_o); else passes++;
    endtask

    task automatic test_write_gap();
        ack_en = 1'b1;
        ack_always = 1'b1;
        run_burst(1'b1, 26'h200, 5'd3, 1, 2);
        ack_always = 1'b0;
        checks++; if (n_ack !== 3) $display("FAIL gap_beats got %0d exp 3", n_ack); else passes++;
        checks++; if (stb_drop !== 1'b1) $display("FAIL gap_wr_wait got %0b exp 1", stb_drop); else passes++;
        checks++; if ({obs_cti[0], obs_cti[1], obs_cti[2]} !== {3'b010, 3'b010, 3'b111}) $display("FAIL gap_cti got %b %b %b exp 010 010 111", obs_cti[0], obs_cti[1], obs_cti[2]); else passes++;
        checks++; if (obs_dat[0] !== wdata(0) || obs_dat[1] !== wdata(1) || obs_dat[2] !== wdata(2)) $display("FAIL gap_data got %h %h %h", obs_dat[0], obs_dat[1], obs_dat[2]); else passes++;
        checks++; if (obs_addr[2] !== 26'h208) $display("FAIL gap_addr got %h exp 208", obs_addr[2]); else passes++;
        checks++; if (done_cyc !== 6) $display("FAIL gap_done got cyc %0d exp 6", done_cyc); else passes++;
    endtask

    task automatic test_read_full();
        ack_en = 1'b1;
        // Unaligned start near the top of the address space: low bits drop,
        // and the 0x80 advance wraps to 0x40.
        run_burst(1'b0, 26'h3FF_FFC3, 5'd0, -1, 0);
        checks++; if (n_ack !== 32 || n_rd !== 32) $display("FAIL full_beats got %0d/%0d exp 32/32", n_ack, n_rd); else passes++;
        checks++; if (obs_addr[0] !== 26'h3FF_FFC0) $display("FAIL full_first_addr got %h exp 3ffffc0", obs_addr[0]); else passes++;
        checks++; if (obs_addr[31] !== 26'h000_003C) $display("FAIL full_last_addr got %h exp 3c", obs_addr[31]); else passes++;
        checks++; if (wb_addr_o !== 26'h000_0040) $display("FAIL full_addr_advance got %h exp 40", wb_addr_o); else passes++;
        checks++; if (last_idx !== 31 || n_last !== 1) $display("FAIL full_rd_last got idx %0d n %0d exp 31/1", last_idx, n_last); else passes++;
        checks++; if (obs_cti[30] !== 3'b010 || obs_cti[31] !== 3'b111) $display("FAIL full_cti got %b %b exp 010 111", obs_cti[30], obs_cti[31]); else passes++;
        checks++; if (obs_rd[31] !== rexp(26'h3C)) $display("FAIL full_last_data got %h exp %h", obs_rd[31], rexp(26'h3C)); else passes++;
    endtask

    task automatic test_timeout();
        int high;
        logic saw_done;
        ack_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 26'h100; req_len = 5'd2;
        step();
        req_valid = 1'b0;
        high = 0; saw_done = 1'b0;
        for (int c = 0; c < 40 && wb_stb_o; c++) begin
            high++;
            if (done) saw_done = 1'b1;
            step();
        end
        checks++; if (high !== 17) $display("FAIL to_stb_cycles got %0d exp 17", high); else passes++;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL to_bus_drop got %b exp 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else passes++;
        checks++; if (err !== 1'b1 || done !== 1'b0 || saw_done) $display("FAIL to_err_pulse got err %0b done %0b exp 1/0", err, done); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL to_req_ready got %0b exp 1", req_ready); else passes++;
        step();
        checks++; if (err !== 1'b0) $display("FAIL to_err_once got %0b exp 0", err); else passes++;
    endtask

    task automatic test_ack_at_limit();
        int stb_bad;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 26'h180; req_len = 5'd1;
        step();
        req_valid = 1'b0;
        checks++; if (wb_cti_o !== 3'b111) $display("FAIL lim_single_cti got %b exp 111", wb_cti_o); else passes++;
        stb_bad = 0;
        for (int k = 0; k <= 16; k++) begin
            if (!wb_stb_o || err) stb_bad++;
            if (k == 16) ack_en = 1'b1;
            step();
        end
        ack_en = 1'b0;
        checks++; if (stb_bad !== 0) $display("FAIL lim_stb_held got %0d bad cycles exp 0", stb_bad); else passes++;
        checks++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL lim_ack_wins got done %0b err %0b exp 1/0", done, err); else passes++;
        checks++; if (rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_data !== rexp(26'h180)) $display("FAIL lim_rd got v%0b l%0b %h exp 1/1 %h", rd_valid, rd_last, rd_data, rexp(26'h180)); else passes++;
    endtask

    task automatic test_reset_mid_burst();
        logic bad_pulse;
        ack_en = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 26'h200; req_len = 5'd4;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (wb_addr_o !== 26'h204 || rd_valid !== 1'b1) $display("FAIL rst_pre_state got addr %h rv %0b exp 204/1", wb_addr_o, rd_valid); else passes++;
        RESETN = 1'b0;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, rd_valid} !== 3'b000) $display("FAIL rst_immediate got %b exp 000", {wb_cyc_o, wb_stb_o, rd_valid}); else passes++;
        step();
        RESETN = 1'b1;
        bad_pulse = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (done || err) bad_pulse = 1'b1;
            step();
        end
        checks++; if (req_ready !== 1'b1 || bad_pulse) $display("FAIL rst_release got ready %0b pulse %0b exp 1/0", req_ready, bad_pulse); else passes++;
        run_burst(1'b0, 26'h300, 5'd2, -1, 0);
        checks++; if (n_ack !== 2 || done_cyc !== 2 || obs_addr[1] !== 26'h304) $display("FAIL rst_next_burst got n %0d done %0d addr %h exp 2/2/304", n_ack, done_cyc, obs_addr[1]); else passes++;
        checks++; if (obs_rd[1] !== rexp(26'h304) || last_idx !== 1) $display("FAIL rst_next_data got %h idx %0d exp %h/1", obs_rd[1], last_idx, rexp(26'h304)); else passes++;
    endtask

    initial begin
        RESETN = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        test_reset();
        RESETN = 1'b1;
        step();
        test_read4();
        test_write8();
        test_write_gap();
        test_read_full();
        test_timeout();
        test_ack_at_limit();
        step();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
